// File: rtl/pipeline_types.sv
// Shared pipeline types: instruction-buffer entry layout and default buffer sizing.
package pipeline_types;

    localparam int unsigned IBUF_DEPTH  = 16;
    localparam int unsigned EXC_CAUSE_W = 7;

    typedef struct packed {
        logic [31:0]            pc;
        logic [31:0]            inst;
        logic                   is_exc;
        logic [EXC_CAUSE_W-1:0] exc_cause;
    } ibuf_entry_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/ibuf_ram.sv
// Instruction-buffer storage: two writes to consecutive slots, two combinational reads.
module ibuf_ram
    import pipeline_types::*;
#(
    parameter int unsigned DEPTH = IBUF_DEPTH
) (
    input  logic                       clk,
    input  logic [1:0]                 wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_idx,
    input  ibuf_entry_t [1:0]          wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output ibuf_entry_t [1:0]          rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    ibuf_entry_t mem [DEPTH];
    logic [AW-1:0] wr_idx1;
    logic [AW-1:0] rd_idx1;

    // Second port always addresses the next slot, wrapping modulo DEPTH.
    assign wr_idx1 = wr_idx + AW'(1);
    assign rd_idx1 = rd_idx + AW'(1);

    always_ff @(posedge clk) begin
        if (wr_en[0]) mem[wr_idx]  <= wr_data[0];
        if (wr_en[1]) mem[wr_idx1] <= wr_data[1];
    end

    assign rd_data[0] = mem[rd_idx];
    assign rd_data[1] = mem[rd_idx1];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Dual-issue fetch-to-decode instruction queue with flush and almost-full backpressure.
// Optional build macro IBUF_PERF_CNT_EN adds saturating full/empty/flush performance counters.
module inst_fetch_buffer
    import pipeline_types::*;
#(
    parameter int unsigned DEPTH       = IBUF_DEPTH,
    parameter int unsigned FULL_MARGIN = 4,
    parameter int unsigned CAUSE_W     = EXC_CAUSE_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_stall,
    input  logic [1:0]              in_valid,
    input  logic [1:0][31:0]        in_pc,
    input  logic [1:0][31:0]        in_inst,
    input  logic [1:0]              in_is_exc,
    input  logic [1:0][CAUSE_W-1:0] in_exc_cause,
    output logic                    buf_full,
    output logic [1:0]              out_valid,
    output logic [1:0][31:0]        out_pc,
    output logic [1:0][31:0]        out_inst,
    output logic [1:0]              out_is_exc,
    output logic [1:0][CAUSE_W-1:0] out_exc_cause,
`ifdef IBUF_PERF_CNT_EN
    output logic [31:0]             perf_full_cycles,
    output logic [31:0]             perf_empty_cycles,
    output logic [31:0]             perf_flush_cnt,
`endif
    input  logic [1:0]              dec_accept
);

    localparam int unsigned AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t DEPTH_P  = ptr_t'(DEPTH);
    localparam ptr_t MARGIN_P = ptr_t'(FULL_MARGIN);

    ptr_t             rd_ptr, wr_ptr, count, free_cnt;
    logic [1:0]       push_mask, push_req, push_n, pop_n, wr_en, accept_eff;
    logic             ovf_err, ovf_set;
    ibuf_entry_t [1:0] slot, wr_data, rd_data;

    assign count     = wr_ptr - rd_ptr;
    assign free_cnt  = DEPTH_P - count;
    assign buf_full  = free_cnt < MARGIN_P;
    assign out_valid = {(count > ptr_t'(1)) && !flush, (count != '0) && !flush};

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            slot[i] = '{pc: in_pc[i], inst: in_inst[i], is_exc: in_is_exc[i],
                        exc_cause: EXC_CAUSE_W'(in_exc_cause[i])};
        end
    end

    always_comb begin
        push_mask = in_valid & {2{~in_stall}};
        push_req  = popcount2(push_mask);
        push_n    = push_req;
        ovf_set   = 1'b0;
        // At most two pushes arrive, so when they exceed free space it is 0 or 1.
        if (ptr_t'(push_req) > free_cnt) begin
            push_n  = free_cnt[1:0];
            ovf_set = 1'b1;
        end
        if (flush) begin
            push_n  = '0;
            ovf_set = 1'b0;
        end
        wr_en      = {push_n == 2'd2, push_n != 2'd0};
        wr_data[0] = push_mask[0] ? slot[0] : slot[1];
        wr_data[1] = slot[1];
        accept_eff = (dec_accept == 2'b10) ? '0 : dec_accept;
        pop_n      = popcount2(accept_eff & out_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + ptr_t'(push_n);
                rd_ptr <= rd_ptr + ptr_t'(pop_n);
            end
            if (ovf_set) ovf_err <= 1'b1;
        end
    end

    ibuf_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_ptr[AW-1:0]),
        .wr_data (wr_data),
        .rd_idx  (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            out_pc[i]        = rd_data[i].pc;
            out_inst[i]      = rd_data[i].inst;
            out_is_exc[i]    = rd_data[i].is_exc;
            out_exc_cause[i] = CAUSE_W'(rd_data[i].exc_cause);
        end
    end

`ifdef IBUF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_full_cycles  <= '0;
            perf_empty_cycles <= '0;
            perf_flush_cnt    <= '0;
        end else begin
            if (buf_full && perf_full_cycles != '1)      perf_full_cycles  <= perf_full_cycles + 32'd1;
            if (count == '0 && perf_empty_cycles != '1)  perf_empty_cycles <= perf_empty_cycles + 32'd1;
            if (flush && perf_flush_cnt != '1)           perf_flush_cnt    <= perf_flush_cnt + 32'd1;
        end
    end
`endif

    a_dec_accept_legal: assert property (@(posedge clk) disable iff (reset) dec_accept != 2'b10);
    a_ovf_err_sticky:   assert property (@(posedge clk) disable iff (reset) ovf_err |=> ovf_err);

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Scoreboard bench for inst_fetch_buffer: a reference queue tracks expected entries cycle by cycle.
module tb_inst_fetch_buffer;
    import pipeline_types::*;

    localparam int DEPTH  = 16;
    localparam int MARGIN = 4;

    logic             clk = 1'b0;
    logic             reset, flush, in_stall, buf_full;
    logic [1:0]       in_valid, in_is_exc, out_valid, out_is_exc, dec_accept;
    logic [1:0][31:0] in_pc, in_inst, out_pc, out_inst;
    logic [1:0][6:0]  in_exc_cause, out_exc_cause;
`ifdef IBUF_PERF_CNT_EN
    logic [31:0]      perf_full_cycles, perf_empty_cycles, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    inst_fetch_buffer #(.DEPTH(DEPTH), .FULL_MARGIN(MARGIN), .CAUSE_W(7)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_stall      (in_stall),
        .in_valid      (in_valid),
        .in_pc         (in_pc),
        .in_inst       (in_inst),
        .in_is_exc     (in_is_exc),
        .in_exc_cause  (in_exc_cause),
        .buf_full      (buf_full),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .out_is_exc    (out_is_exc),
        .out_exc_cause (out_exc_cause),
`ifdef IBUF_PERF_CNT_EN
        .perf_full_cycles  (perf_full_cycles),
        .perf_empty_cycles (perf_empty_cycles),
        .perf_flush_cnt    (perf_flush_cnt),
`endif
        .dec_accept    (dec_accept)
    );

    ibuf_entry_t model_q[$];
    bit          ovf_exp;
    int          n_cmp, n_err;
    logic [31:0] pc_run;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ibuf_entry_t mk_entry(input logic [31:0] pc);
        ibuf_entry_t e;
        e.pc        = pc;
        e.inst      = {pc[15:0], ~pc[15:0]} ^ $urandom;
        e.is_exc    = 1'($urandom_range(0, 1));
        e.exc_cause = 7'($urandom);
        return e;
    endfunction

    // One clock: drive inputs, check outputs against the model at negedge, then advance the model.
    task automatic cycle(input logic [1:0] iv, input logic st, input logic [1:0] acc,
                         input logic fl, input logic rs, input logic [31:0] pc0);
        ibuf_entry_t e0, e1, nq[$];
        logic [1:0]  ev;
        int          free, pops;
        e0 = mk_entry(pc0);
        e1 = mk_entry(pc0 + 32'd4);
        in_valid = iv; in_stall = st; dec_accept = acc; flush = fl; reset = rs;
        in_pc[0] = e0.pc; in_inst[0] = e0.inst; in_is_exc[0] = e0.is_exc; in_exc_cause[0] = e0.exc_cause;
        in_pc[1] = e1.pc; in_inst[1] = e1.inst; in_is_exc[1] = e1.is_exc; in_exc_cause[1] = e1.exc_cause;
        @(negedge clk);
        ev = fl ? 2'b00 : (model_q.size() >= 2 ? 2'b11 : (model_q.size() == 1 ? 2'b01 : 2'b00));
        check_val("out_valid", 128'(out_valid), 128'(ev));
        check_val("buf_full", 128'(buf_full), 128'((DEPTH - model_q.size()) < MARGIN));
        check_val("ovf_err", 128'(dut.ovf_err), 128'(ovf_exp));
        if (ev[0]) check_val("head0", 128'({out_pc[0], out_inst[0], out_is_exc[0], out_exc_cause[0]}), 128'(model_q[0]));
        if (ev[1]) check_val("head1", 128'({out_pc[1], out_inst[1], out_is_exc[1], out_exc_cause[1]}), 128'(model_q[1]));
        if (rs) begin
            model_q.delete();
            ovf_exp = 1'b0;
        end else if (fl) begin
            model_q.delete();
        end else begin
            free = DEPTH - model_q.size();
            if (iv[0] && !st) nq.push_back(e0);
            if (iv[1] && !st) nq.push_back(e1);
            pops = int'(acc[0] & ev[0]) + int'(acc[1] & ev[1]);
            repeat (pops) void'(model_q.pop_front());
            foreach (nq[i]) begin
                if (free > 0) begin
                    model_q.push_back(nq[i]);
                    free--;
                end else begin
                    ovf_exp = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] iv, input logic [1:0] acc);
        cycle(iv, 1'b0, acc, 1'b0, 1'b0, pc_run);
        pc_run += 32'd8;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; ovf_exp = 1'b0; pc_run = 32'h1c00_0100;
        reset = 1'b1; flush = 1'b0; in_stall = 1'b0; in_valid = '0; dec_accept = '0;
        in_pc = '0; in_inst = '0; in_is_exc = '0; in_exc_cause = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and basic push/pop ordering
        cycle(2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 32'h1c00_0000);
        push(2'b00, 2'b00);
        push(2'b00, 2'b11);
        push(2'b00, 2'b00);

        // Odd slot compaction
        cycle(2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 32'h1c00_0010);
        cycle(2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 32'h1c00_0018);
        push(2'b00, 2'b00);
        push(2'b00, 2'b11);

        // Fill to almost-full, overflow, then in-order drain
        repeat (6) push(2'b11, 2'b00);
        push(2'b01, 2'b00);
        repeat (2) push(2'b11, 2'b00);
        push(2'b00, 2'b00);
        repeat (9) push(2'b00, 2'b11);

        // Flush with concurrent push and pop
        repeat (4) push(2'b11, 2'b00);
        push(2'b01, 2'b00);
        cycle(2'b11, 1'b0, 2'b11, 1'b1, 1'b0, pc_run);
        push(2'b11, 2'b00);
        push(2'b00, 2'b00);
        push(2'b00, 2'b11);

        // Stall blocks pushes, then random traffic across the pointer wrap
        cycle(2'b11, 1'b1, 2'b00, 1'b0, 1'b0, pc_run);
        push(2'b00, 2'b00);
        for (int i = 0; i < 40; i++) begin
            logic [1:0] iv, acc;
            iv  = 2'($urandom_range(0, 3));
            acc = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
            push(iv, acc);
        end

        // Reset mid-stream with five entries queued
        cycle(2'b00, 1'b0, 2'b00, 1'b1, 1'b0, pc_run);
        push(2'b11, 2'b00);
        push(2'b11, 2'b00);
        push(2'b01, 2'b00);
        cycle(2'b11, 1'b0, 2'b00, 1'b0, 1'b1, pc_run);
`ifdef IBUF_PERF_CNT_EN
        check_val("perf_full", 128'(perf_full_cycles), 128'(0));
        check_val("perf_empty", 128'(perf_empty_cycles), 128'(0));
        check_val("perf_flush", 128'(perf_flush_cnt), 128'(0));
`endif
        push(2'b00, 2'b00);
        push(2'b11, 2'b00);
        push(2'b00, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
